// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read
// latency in a 2-entry prefetch buffer and presents a valid/ready stream.
module fifo_stream_reader #(
    parameter int unsigned Width    = 8,
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic                o_fifo_rd_en,
    input  logic [Width-1:0]    i_fifo_rd_data,
    input  logic                i_fifo_empty,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [Width-1:0]    o_data,
    output logic [CntWidth-1:0] o_count,
    output logic                o_stall
);

    localparam int unsigned OccWidth = 2;
    localparam int unsigned SumWidth = OccWidth + 1;
    localparam logic [SumWidth-1:0] Depth    = SumWidth'(2);
    localparam logic [CntWidth-1:0] CountMax = '1;

    logic [Width-1:0]    buf_q [2];
    logic                head_q;
    logic                tail_q;
    logic [OccWidth-1:0] occ_q;
    logic                inflight_q;
    logic [CntWidth-1:0] count_q;
    logic                stall_q;

    logic                pop_c;
    logic [SumWidth-1:0] occ_next_c;

    // Pop handshake, projected occupancy and the read-issue decision
    always_comb begin
        pop_c        = 1'b0;
        occ_next_c   = '0;
        o_fifo_rd_en = 1'b0;
        pop_c        = o_valid & i_ready;
        occ_next_c   = SumWidth'(occ_q) + SumWidth'(inflight_q) - SumWidth'(pop_c);
        o_fifo_rd_en = ~i_fifo_empty & (occ_next_c < Depth);
    end

    assign o_valid = (occ_q != '0);
    assign o_data  = buf_q[head_q];
    assign o_count = count_q;
    assign o_stall = stall_q;

    // Prefetch buffer storage and tail pointer: capture the word requested last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            tail_q   <= 1'b0;
        end else if (inflight_q) begin
            buf_q[tail_q] <= i_fifo_rd_data;
            tail_q        <= ~tail_q;
        end
    end

    // Head pointer, occupancy and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= o_fifo_rd_en;
            occ_q      <= OccWidth'(occ_next_c);
            if (pop_c) begin
                head_q <= ~head_q;
            end
        end
    end

    // Saturating delivered-word counter and registered back-pressure flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            if (pop_c && (count_q != CountMax)) begin
                count_q <= count_q + CntWidth'(1);
            end
            stall_q <= o_valid & ~i_ready;
        end
    end

    // A capture into a full buffer without a pop would overwrite the head word
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(inflight_q && (occ_q == OccWidth'(2)) && !pop_c));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty;
    logic        valid;
    logic        ready = 1'b0;
    logic [7:0]  data;
    logic [15:0] count;
    logic        stall;

    logic        rd_en4;
    logic        valid4;
    logic [7:0]  data4;
    logic [3:0]  count4;
    logic        stall4;

    logic [7:0]  mem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr;
    logic        hold_empty = 1'b0;

    logic [7:0]  out_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          diverge = 0;
    logic        rd_en_seen = 1'b0;

    fifo_stream_reader #(.Width(8), .CntWidth(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .o_fifo_rd_en   (fifo_rd_en),
        .i_fifo_rd_data (fifo_rd_data),
        .i_fifo_empty   (fifo_empty),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_data         (data),
        .o_count        (count),
        .o_stall        (stall)
    );

    // Narrow-counter copy sharing every input; only its count should differ
    fifo_stream_reader #(.Width(8), .CntWidth(4)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .o_fifo_rd_en   (rd_en4),
        .i_fifo_rd_data (fifo_rd_data),
        .i_fifo_empty   (fifo_empty),
        .o_valid        (valid4),
        .i_ready        (ready),
        .o_data         (data4),
        .o_count        (count4),
        .o_stall        (stall4)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO read port: data appears one cycle after an accepted read
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= 0;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    assign fifo_empty = rst | hold_empty | (rd_ptr >= wr_ptr);

    // Collect delivered words and watch both instances for divergence
    always @(posedge clk) begin
        if (!rst && valid && ready) out_q.push_back(data);
        if (!rst && fifo_rd_en) rd_en_seen = 1'b1;
        if ((rd_en4 !== fifo_rd_en) || (valid4 !== valid) ||
            (data4 !== data) || (stall4 !== stall)) diverge++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready = 1'b0; hold_empty = 1'b0; wr_ptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_q.delete();
        rd_en_seen = 1'b0;
    endtask

    task automatic compare_seq(input string tag, input int n);
        int errs = 0;
        for (int k = 0; k < n && k < out_q.size(); k++)
            if (out_q[k] !== mem[k]) errs++;
        check({tag, "_len"}, 32'(out_q.size()), 32'(n));
        check({tag, "_order"}, 32'(errs), 32'(0));
    endtask

    // Full-rate stream of n words starting at base with ready held high
    task automatic stream_run(input string tag, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) mem[k] = 8'(int'(base) + k);
        @(negedge clk);
        ready  = 1'b1;
        wr_ptr = n;
        #1 check({tag, "_first_rden"}, 32'(fifo_rd_en), 32'(1));
        @(posedge clk); #1 check({tag, "_latency_n1"}, 32'(valid), 32'(0));
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            check({tag, "_valid"}, 32'(valid), 32'(1));
            check({tag, "_data"}, 32'(data), 32'(8'(int'(base) + k)));
            check({tag, "_count"}, 32'(count), 32'(k));
            check({tag, "_count4"}, 32'(count4), 32'(k > 15 ? 15 : k));
            @(posedge clk); #1;
        end
        check({tag, "_drained"}, 32'(valid), 32'(0));
        check({tag, "_count_end"}, 32'(count), 32'(n));
        check({tag, "_count4_end"}, 32'(count4), 32'(n > 15 ? 15 : n));
        compare_seq(tag, n);
    endtask

    initial begin
        int cycles;

        // Reset and idle
        @(negedge clk);
        check("rst_rden", 32'(fifo_rd_en), 32'(0));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        rd_en_seen = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_rden_seen", 32'(rd_en_seen), 32'(0));
        check("idle_valid", 32'(valid), 32'(0));
        check("idle_count", 32'(count), 32'(0));
        check("idle_stall", 32'(stall), 32'(0));

        // Streaming 0x01..0x10
        stream_run("stream", 16, 8'h01);

        // Counter saturation on the 4-bit instance
        do_reset();
        stream_run("sat", 20, 8'h30);

        // Back-pressure mid-stream
        do_reset();
        for (int k = 0; k < 8; k++) mem[k] = 8'hA0 + 8'(k);
        @(negedge clk);
        ready  = 1'b1;
        wr_ptr = 8;
        @(posedge clk); #1;
        @(posedge clk); #1 check("bp_data0", 32'(data), 32'hA0);
        @(posedge clk); #1 check("bp_data1", 32'(data), 32'hA1);
        @(posedge clk); #1 check("bp_data2", 32'(data), 32'hA2);
        @(negedge clk);
        ready = 1'b0;
        #1 check("bp_rden_drop", 32'(fifo_rd_en), 32'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(valid), 32'(1));
            check("bp_hold_data", 32'(data), 32'hA2);
            check("bp_stall", 32'(stall), 32'(1));
            check("bp_rden_low", 32'(fifo_rd_en), 32'(0));
        end
        @(negedge clk);
        ready = 1'b1;
        cycles = 0;
        while (out_q.size() < 8 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        @(posedge clk); #1;
        check("bp_stall_clear", 32'(stall), 32'(0));
        check("bp_count", 32'(count), 32'(8));
        compare_seq("bp", 8);

        // Random ready and empty over 1000 words
        do_reset();
        for (int k = 0; k < 1000; k++) mem[k] = 8'($urandom);
        @(negedge clk);
        wr_ptr = 1000;
        cycles = 0;
        while (out_q.size() < 1000 && cycles < 30000) begin
            ready      = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            cycles++;
        end
        ready = 1'b0; hold_empty = 1'b0;
        @(posedge clk); #1;
        check("rand_count", 32'(count), 32'(1000));
        check("rand_count4", 32'(count4), 32'(15));
        compare_seq("rand", 1000);

        // Asynchronous reset with a word buffered and one in flight
        do_reset();
        for (int k = 0; k < 8; k++) mem[k] = 8'hC0 + 8'(k);
        @(negedge clk);
        wr_ptr = 8;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_pre_valid", 32'(valid), 32'(1));
        check("mid_pre_data", 32'(data), 32'hC0);
        #1;
        rst = 1'b1;
        wr_ptr = 0;
        #1;
        check("mid_valid", 32'(valid), 32'(0));
        check("mid_data", 32'(data), 32'(0));
        check("mid_count", 32'(count), 32'(0));
        check("mid_stall", 32'(stall), 32'(0));
        check("mid_rden", 32'(fifo_rd_en), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_en_seen = 1'b0;
        out_q.delete();
        ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rden_seen", 32'(rd_en_seen), 32'(0));
        check("post_valid", 32'(valid), 32'(0));
        check("post_words", 32'(out_q.size()), 32'(0));
        check("post_count", 32'(count), 32'(0));

        check("instances_agree", 32'(diverge), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
